// File: rtl/encoder_8to3_pend.sv
// encoder_8to3_pend: pending-request 8-to-3 priority encoder with valid/ack handshake
//
// Collects request lines into a pending register and presents the
// highest-priority pending index as a binary code until it is acknowledged.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   en       capture/grant enable
//   req      request lines, bit i requests code i
//   ack      consumer accepts the presented code
//   code     granted index, stable while valid
//   valid    code is valid
//   onehot   decoded code while valid, else zero
//   pending  pending-request register
//   dup      one-cycle pulse when an already-pending bit is requested again
module encoder_8to3_pend #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] onehot,
    output logic [7:0] pending,
    output logic       dup
);
    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    state_t     r_state, w_state_nx;
    logic [7:0] r_pend;
    logic [2:0] r_code, w_code_nx, w_prio;
    logic       r_valid, w_valid_nx, r_dup;
    logic [7:0] w_set, w_clr;

    assign w_set = en ? req : 8'h00;
    // only the presented code is cleared, and only on a real handshake
    assign w_clr = (r_state == S_PRESENT && ack) ? 8'b1 << r_code : 8'h00;

    // later matches overwrite earlier ones, so scan order sets the priority
    always_comb begin
        w_prio = 3'd0;
        for (int i = 0; i < 8; i++)
            if (LOW_FIRST ? r_pend[7-i] : r_pend[i])
                w_prio = LOW_FIRST ? 3'(7 - i) : 3'(i);
    end

    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_valid_nx = r_valid;
        if (r_state == S_IDLE) begin
            if (en && |r_pend) begin
                w_state_nx = S_PRESENT;
                w_code_nx  = w_prio;
                w_valid_nx = 1'b1;
            end
        end else if (ack) begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pend  <= 8'h00;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
            r_dup   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_dup   <= |(w_set & r_pend & ~w_clr);
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pend;
    assign dup     = r_dup;
    assign onehot  = r_valid ? 8'b1 << r_code : 8'h00;
endmodule

// File: tb/tb_encoder_8to3_pend.sv
// tb_encoder_8to3_pend: directed self-checking bench for encoder_8to3_pend
module tb_encoder_8to3_pend;
    logic       clk = 1'b0;
    logic       reset_n, en, ack;
    logic [7:0] req;
    logic [2:0] code, lo_code;
    logic       valid, dup, lo_valid, lo_dup;
    logic [7:0] onehot, pending, lo_onehot, lo_pending;
    int         n_cmp = 0;
    int         n_err = 0;

    encoder_8to3_pend #(.LOW_FIRST(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .req(req), .ack(ack),
        .code(code), .valid(valid), .onehot(onehot), .pending(pending), .dup(dup)
    );

    encoder_8to3_pend #(.LOW_FIRST(1'b1)) u_lo (
        .clk(clk), .reset_n(reset_n), .en(en), .req(req), .ack(ack),
        .code(lo_code), .valid(lo_valid), .onehot(lo_onehot), .pending(lo_pending), .dup(lo_dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; req = 8'hFF; ack = 1'b0;
        // 1. reset
        step(); step();
        chk("rst_pend", pending, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_onehot", onehot, 8'h00);
        chk("rst_dup", dup, 0);
        #2 reset_n = 1'b1; req = 8'h00;
        step(); step();
        chk("rst_idle_valid", valid, 0);
        chk("rst_idle_pend", pending, 8'h00);
        // 2. single request
        req = 8'h20;
        step(); req = 8'h00;
        chk("single_pend", pending, 8'h20);
        chk("single_nvalid", valid, 0);
        step();
        chk("single_valid", valid, 1);
        chk("single_code", code, 5);
        chk("single_onehot", onehot, 8'h20);
        ack = 1'b1;
        step(); ack = 1'b0;
        chk("single_ack_valid", valid, 0);
        chk("single_ack_pend", pending, 8'h00);
        chk("single_ack_onehot", onehot, 8'h00);
        // 3. priority, both orderings
        req = 8'h85;
        step(); req = 8'h00;
        chk("prio_pend0", pending, 8'h85);
        step();
        chk("prio_code7", code, 7);
        chk("prio_lo_code0", lo_code, 0);
        ack = 1'b1; step(); ack = 1'b0;
        chk("prio_pend1", pending, 8'h05);
        chk("prio_lo_pend1", lo_pending, 8'h84);
        chk("prio_gap", valid, 0);
        step();
        chk("prio_code2", code, 2);
        chk("prio_lo_code2", lo_code, 2);
        ack = 1'b1; step(); ack = 1'b0;
        chk("prio_pend2", pending, 8'h01);
        step();
        chk("prio_code0", code, 0);
        chk("prio_lo_code7", lo_code, 7);
        ack = 1'b1; step(); ack = 1'b0;
        chk("prio_pend3", pending, 8'h00);
        chk("prio_lo_pend3", lo_pending, 8'h00);
        // ack while idle is ignored
        ack = 1'b1; step(); ack = 1'b0;
        chk("idle_ack_valid", valid, 0);
        // 4. same-edge set/clear and dup
        req = 8'h08; step(); req = 8'h00; step();
        chk("sc_code3", code, 3);
        ack = 1'b1; req = 8'h08;
        step(); ack = 1'b0; req = 8'h00;
        chk("sc_pend", pending, 8'h08);
        chk("sc_dup0", dup, 0);
        chk("sc_valid0", valid, 0);
        step();
        chk("sc_regrant_valid", valid, 1);
        chk("sc_regrant_code", code, 3);
        req = 8'h08; step(); req = 8'h00;
        chk("dup_pulse", dup, 1);
        chk("dup_hold_code", code, 3);
        step();
        chk("dup_clear", dup, 0);
        ack = 1'b1; step(); ack = 1'b0;
        chk("dup_drain", pending, 8'h00);
        // 5. enable rules
        en = 1'b0; req = 8'h01; step(); step(); req = 8'h00;
        chk("en0_pend", pending, 8'h00);
        chk("en0_valid", valid, 0);
        en = 1'b1; req = 8'h11; step(); req = 8'h00; step();
        chk("en_code4", code, 4);
        en = 1'b0; req = 8'h02; step(); step(); req = 8'h00;
        chk("en_hold_valid", valid, 1);
        chk("en_hold_code", code, 4);
        chk("en_hold_pend", pending, 8'h11);
        ack = 1'b1; step(); ack = 1'b0;
        chk("en_ack_pend", pending, 8'h01);
        step(); step();
        chk("en_nogrant", valid, 0);
        en = 1'b1; step();
        chk("en_grant0", code, 0);
        chk("en_grant0_valid", valid, 1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("en_drain", pending, 8'h00);
        // 6. async reset mid-present
        req = 8'h40; step(); req = 8'h00; step();
        chk("ar_code6", code, 6);
        chk("ar_valid1", valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", valid, 0);
        chk("ar_pend", pending, 8'h00);
        chk("ar_onehot", onehot, 8'h00);
        #1 reset_n = 1'b1;
        step(); step();
        chk("ar_after", valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
